ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

PS/2 device-to-host receiver with an input FIFO. It synchronises the raw `ps2_clk`/`ps2_data` lines into the `clk_50m` domain, deserialises 11-bit frames, and queues valid scancode bytes in a FIFO. The downstream scancode decoder consumes them through the `ready`/`nextdata_n` handshake. Errors are reported through `overflow` and `frame_err`.

## Interface
- `FIFO_AW`, default 3: FIFO address width; depth = 2^FIFO_AW = 8 entries.
- `TIMEOUT_CYC`, default 50000: idle `clk_50m` cycles mid-frame before the bit counter aborts (1 ms).
- `clk_50m` input 1: the single system clock; all logic runs on its rising edge.
- `clr` input 1: reset, asynchronous, active-high.
- `ps2_clk` input 1: raw PS/2 clock line, asynchronous.
- `ps2_data` input 1: raw PS/2 data line, asynchronous.
- `data` output 8: byte at the FIFO head; valid only while `ready`=1.
- `ready` output 1: FIFO non-empty.
- `nextdata_n` input 1: active-low pop request from the consumer.
- `overflow` output 1: sticky; a completed frame was dropped because the FIFO was full.
- `frame_err` output 1: sticky; a frame was discarded for a start/stop (or parity, see Configuration) error.

## Operation
- Synchroniser:
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser.
  - A third flop on the clock path holds the previous synchronised clock value.
  - Falling edge = previous 1, current 0. Synchronised data is sampled in that same cycle.
- Frame format, sampled in order on successive falling edges:
  - start bit (0);
  - 8 data bits, LSB first;
  - odd-parity bit;
  - stop bit (1).
- Receive state machine:
  - IDLE: on a falling edge with data=0, go to SHIFT with bit count 1. A falling edge with data=1 is ignored.
  - SHIFT: shift in bits 1–10 and reset the idle timer on each edge. When the 11th bit is sampled, go to CHECK.
  - CHECK: lasts exactly one cycle.
    - Valid frame: push the byte, return to IDLE.
    - Invalid frame: set `frame_err`, push nothing, return to IDLE.
  - Timeout: in SHIFT, if no falling edge arrives for `TIMEOUT_CYC` cycles, return to IDLE and discard partial bits. `frame_err` is not set.
- FIFO:
  - Read and write pointers are FIFO_AW+1 bits wide; the extra MSB distinguishes full from empty.
  - Empty: pointers equal.
  - Full: low bits equal and MSBs differ.
  - Pointers wrap modulo 2^(FIFO_AW+1).
  - `data` is the combinational read of the entry at the read pointer.
- Pop: occurs on the rising edge where `ready`=1 and `nextdata_n`=0. `nextdata_n`=0 while empty is ignored.
- Push when full:
  - With a pop in the same cycle: the push succeeds and `overflow` is not set.
  - Without a pop: the byte is dropped and `overflow` is set.
- Push and pop in the same cycle on a non-empty FIFO: both take effect; occupancy is unchanged.
- Push into an empty FIFO: `data` shows the new byte the cycle `ready` rises.
- `overflow` and `frame_err` clear only on `clr`.

## Timing
- Reset values:
  - `ready`=0, `overflow`=0, `frame_err`=0.
  - `data`=8'h00 (all FIFO entries cleared).
  - Pointers 0, state IDLE, timer 0, all synchroniser flops 1 (idle bus).
- `clr` mid-frame: the partial frame is lost. After release, reception restarts at the next start bit.
- Latency, `ps2_data` to detect: from a `ps2_clk` falling transition, the edge is detected 3 `clk_50m` edges later.
- Latency, detect to output: CHECK follows in the next cycle, and `ready`/`data` update on the edge ending CHECK.
- Pop to `data`: after a pop edge, `data` shows the next entry from the following cycle. `ready` falls in that cycle if the FIFO is now empty.
- Handshake: the consumer holds `nextdata_n` low for exactly one cycle per byte. A low level lasting N cycles pops up to N bytes.
- The PS/2 clock (10–16.7 kHz) is far slower than `clk_50m`, so at most one edge is in flight at a time.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: CHECK requires all of the following; otherwise the frame is discarded and `frame_err` is set:
  - start=0;
  - stop=1;
  - XOR of the 8 data bits and the parity bit = 1.
- `PS2_PARITY_CHECK_EN` undefined:
  - The parity bit is sampled but ignored.
  - Only start/stop errors set `frame_err`.

## Test plan
- Frame 0x1C with parity 0 and stop 1 -> `ready`=1, `data`=8'h1C. After a one-cycle `nextdata_n`=0 pulse, `ready`=0.
- Frames 0xF0 (parity 1) then 0x1C, no pops -> read 8'hF0 then 8'h1C. `ready` drops after the second pop.
- Nine frames 0x01..0x09, no pops:
  - `overflow`=1 after the ninth frame.
  - Pops return 0x01..0x08; 0x09 is lost.
  - Then `clr` -> `overflow`=0.
- Frame 0x1C with parity bit 1:
  - With the macro: no push, `frame_err`=1.
  - Without the macro: `data`=8'h1C, `frame_err`=0.
- Five bits, then 50000+ idle cycles, then a full frame 0x5A (parity 1) -> `data`=8'h5A and `frame_err`=0.
- FIFO full, and a ninth frame's CHECK cycle coincides with `nextdata_n`=0 -> `overflow` stays 0 and occupancy stays 8. Separately, `clr` asserted mid-frame -> all outputs at reset values, and the next full frame is received.

Source files
------------

// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side handshake between the PS/2 receive FIFO and the scancode decoder.
// master = FIFO side (drives data/ready), slave = consumer side (drives nextdata_n).
interface ps2_rx_fifo_if;
    logic [7:0] data;
    logic       ready;
    logic       nextdata_n;

    modport master (output data, output ready, input nextdata_n);
    modport slave  (input data, input ready, output nextdata_n);
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the raw lines, deserialises 11-bit frames
// and queues valid bytes in a FIFO. Define PS2_PARITY_CHECK_EN to reject odd-parity errors.
module ps2_rx_fifo #(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic            clk_50m_i,
    input  logic            clr_i,
    input  logic            ps2_clk_i,
    input  logic            ps2_data_i,
    ps2_rx_fifo_if.master   cons,
    output logic            overflow_o,
    output logic            frame_err_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_e;

    state_e              state_q, state_d;
    logic [2:0]          clkSync_q;
    logic [1:0]          dataSync_q;
    logic [10:0]         shift_q;
    logic [3:0]          bitCnt_q;
    logic [TW-1:0]       timer_q;
    logic [7:0]          mem_q [DEPTH];
    logic [FIFO_AW:0]    wptr_q, rptr_q;
    logic                overflow_q, frameErr_q;

    logic fallEdge, bitIn, timeout;
    logic frameOk, push, badFrame;
    logic empty, full, pop, wrEn;

    // [0] metastability flop, [1] synchronised value, [2] previous synchronised clock
    always_ff @(posedge clk_50m_i or posedge clr_i) begin
        if (clr_i) begin
            clkSync_q  <= 3'b111;
            dataSync_q <= 2'b11;
        end else begin
            clkSync_q  <= {clkSync_q[1:0], ps2_clk_i};
            dataSync_q <= {dataSync_q[0], ps2_data_i};
        end
    end

    assign fallEdge = clkSync_q[2] & ~clkSync_q[1];
    assign bitIn    = dataSync_q[1];
    assign timeout  = (timer_q == TW'(TIMEOUT_CYC - 1)) && !fallEdge;

    always_ff @(posedge clk_50m_i or posedge clr_i) begin
        if (clr_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fallEdge && !bitIn) state_d = SHIFT;
            SHIFT:   begin
                if (fallEdge && bitCnt_q == 4'd10) state_d = CHECK;
                else if (timeout)                  state_d = IDLE;
            end
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bits enter at the top, so after 11 samples the start bit sits at [0] and the stop bit at [10]
    always_ff @(posedge clk_50m_i or posedge clr_i) begin
        if (clr_i) begin
            shift_q  <= '0;
            bitCnt_q <= '0;
            timer_q  <= '0;
        end else begin
            if (state_q == IDLE && fallEdge && !bitIn) begin
                shift_q  <= {bitIn, 10'b0};
                bitCnt_q <= 4'd1;
            end else if (state_q == SHIFT && fallEdge) begin
                shift_q  <= {bitIn, shift_q[10:1]};
                bitCnt_q <= bitCnt_q + 4'd1;
            end
            if (state_q == SHIFT && !fallEdge) timer_q <= timer_q + TW'(1);
            else                               timer_q <= '0;
        end
    end

    always_comb begin
`ifdef PS2_PARITY_CHECK_EN
        frameOk = !shift_q[0] && shift_q[10] && (^shift_q[9:1]);
`else
        frameOk = !shift_q[0] && shift_q[10];
`endif
        push     = (state_q == CHECK) && frameOk;
        badFrame = (state_q == CHECK) && !frameOk;
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]) && (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]);
    assign pop   = !empty && !cons.nextdata_n;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign wrEn  = push && (!full || pop);

    always_ff @(posedge clk_50m_i or posedge clr_i) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wrEn) begin
                mem_q[wptr_q[FIFO_AW-1:0]] <= shift_q[8:1];
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop) rptr_q <= rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_50m_i or posedge clr_i) begin
        if (clr_i) begin
            overflow_q <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            if (push && full && !pop) overflow_q <= 1'b1;
            if (badFrame)             frameErr_q <= 1'b1;
        end
    end

    assign cons.data   = mem_q[rptr_q[FIFO_AW-1:0]];
    assign cons.ready  = !empty;
    assign overflow_o  = overflow_q;
    assign frame_err_o = frameErr_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: drives PS/2 frames, keeps a queue-based model of the FIFO
// and sticky flags, and compares the DUT against it on every cycle outside reset.
module tb_ps2_rx_fifo;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic ps2Clk = 1'b1;
    logic ps2Data = 1'b1;
    logic overflow, frameErr;

    ps2_rx_fifo_if bus();

    ps2_rx_fifo #(.FIFO_AW(3), .TIMEOUT_CYC(50000)) dut (
        .clk_50m_i   (clk),
        .clr_i       (clr),
        .ps2_clk_i   (ps2Clk),
        .ps2_data_i  (ps2Data),
        .cons        (bus),
        .overflow_o  (overflow),
        .frame_err_o (frameErr)
    );

    always #10 clk = ~clk;

    int asserts = 0;
    int failures = 0;
    bit running = 0;

    logic [7:0]  modelQ[$];
    bit          modelOvf = 0;
    bit          modelErr = 0;
    int          cyc = 0;
    bit          pendValid = 0;
    logic [10:0] pendBits = '0;
    int          pendDue = 0;
    bit          popNow, pushNow;

    // Comparison helper shared by the per-cycle compare process and the directed checks
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mkFrame(input logic [7:0] d, input bit par, input bit stop);
        return {stop, par, d, 1'b0};
    endfunction

    function automatic bit frameValid(input logic [10:0] b);
        bit ok;
        ok = (b[0] == 1'b0) && (b[10] == 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        ok = ok && ((^b[9:1]) == 1'b1);
`endif
        return ok;
    endfunction

    // A completed frame becomes visible on the 4th rising edge after its 11th falling edge
    initial forever begin
        @(posedge clk);
        cyc++;
        if (clr) begin
            modelQ.delete();
            modelOvf  = 0;
            modelErr  = 0;
            pendValid = 0;
        end else begin
            popNow  = (modelQ.size() > 0) && (bus.nextdata_n == 1'b0);
            pushNow = 0;
            if (pendValid && cyc == pendDue) begin
                pendValid = 0;
                if (frameValid(pendBits)) pushNow = 1;
                else                      modelErr = 1;
            end
            if (pushNow && modelQ.size() == 8 && !popNow) begin
                modelOvf = 1;
                pushNow  = 0;
            end
            if (popNow)  void'(modelQ.pop_front());
            if (pushNow) modelQ.push_back(pendBits[8:1]);
        end
    end

    // Per-cycle comparison against the model, sampled on the falling clock edge
    initial forever begin
        @(negedge clk);
        if (running && !clr) begin
            checkOutput("cyc_ready", bus.ready, modelQ.size() != 0);
            checkOutput("cyc_overflow", overflow, modelOvf);
            checkOutput("cyc_frame_err", frameErr, modelErr);
            if (modelQ.size() != 0) checkOutput("cyc_data", bus.data, modelQ[0]);
        end
    end

    // Drives nbits of a frame LSB first; optionally pulses nextdata_n during the CHECK cycle
    task automatic applyStimulus(input logic [10:0] bits, input int nbits, input bit popAtCheck);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2Data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2Clk = 1'b0;
            if (i == 10) begin
                pendBits  = bits;
                pendDue   = cyc + 4;
                pendValid = 1;
            end
            if (i == 10 && popAtCheck) begin
                repeat (3) @(negedge clk);
                bus.nextdata_n = 1'b0;
                @(negedge clk);
                bus.nextdata_n = 1'b1;
                repeat (HALF - 4) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2Clk = 1'b1;
        end
        @(negedge clk);
        ps2Data = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic popCheck(input string name, input logic [7:0] exp);
        @(negedge clk);
        checkOutput(name, bus.data, exp);
        bus.nextdata_n = 1'b0;
        @(negedge clk);
        bus.nextdata_n = 1'b1;
    endtask

    task automatic pulseClr();
        @(negedge clk);
        clr = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.nextdata_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", bus.ready, 1'b0);
        checkOutput("rst_data", bus.data, 8'h00);
        checkOutput("rst_overflow", overflow, 1'b0);
        checkOutput("rst_frame_err", frameErr, 1'b0);
        clr = 1'b0;
        running = 1;

        // Single frame, single pop
        applyStimulus(mkFrame(8'h1C, 1'b0, 1'b1), 11, 1'b0);
        checkOutput("t1_ready", bus.ready, 1'b1);
        popCheck("t1_data", 8'h1C);
        checkOutput("t1_ready_after_pop", bus.ready, 1'b0);

        // Two frames queued, read in order
        applyStimulus(mkFrame(8'hF0, 1'b1, 1'b1), 11, 1'b0);
        applyStimulus(mkFrame(8'h1C, 1'b0, 1'b1), 11, 1'b0);
        popCheck("t2_first", 8'hF0);
        checkOutput("t2_ready_mid", bus.ready, 1'b1);
        popCheck("t2_second", 8'h1C);
        checkOutput("t2_ready_end", bus.ready, 1'b0);

        // Overflow: nine frames into an eight-entry FIFO
        for (int i = 1; i <= 9; i++) begin
            logic [7:0] d;
            d = 8'(i);
            applyStimulus(mkFrame(d, ~^d, 1'b1), 11, 1'b0);
        end
        checkOutput("t3_overflow", overflow, 1'b1);
        checkOutput("t3_model_depth", modelQ.size(), 8);
        for (int i = 1; i <= 8; i++) popCheck($sformatf("t3_pop%0d", i), 8'(i));
        checkOutput("t3_empty", bus.ready, 1'b0);
        checkOutput("t3_overflow_sticky", overflow, 1'b1);
        pulseClr();
        checkOutput("t3_overflow_clr", overflow, 1'b0);

        // Bad parity
        applyStimulus(mkFrame(8'h1C, 1'b1, 1'b1), 11, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        checkOutput("t4_ready", bus.ready, 1'b0);
        checkOutput("t4_frame_err", frameErr, 1'b1);
        pulseClr();
`else
        checkOutput("t4_frame_err", frameErr, 1'b0);
        popCheck("t4_data", 8'h1C);
`endif

        // Timeout discards a partial frame without flagging an error
        applyStimulus(mkFrame(8'h5A, 1'b1, 1'b1), 5, 1'b0);
        repeat (50010) @(negedge clk);
        applyStimulus(mkFrame(8'h5A, 1'b1, 1'b1), 11, 1'b0);
        checkOutput("t5_frame_err", frameErr, 1'b0);
        popCheck("t5_data", 8'h5A);

        // Full FIFO with a pop landing on the CHECK cycle of the ninth frame
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            d = 8'h11 + 8'(i);
            applyStimulus(mkFrame(d, ~^d, 1'b1), 11, 1'b0);
        end
        applyStimulus(mkFrame(8'h99, 1'b1, 1'b1), 11, 1'b1);
        checkOutput("t6_overflow", overflow, 1'b0);
        checkOutput("t6_model_depth", modelQ.size(), 8);
        for (int i = 1; i < 8; i++) popCheck($sformatf("t6_pop%0d", i), 8'h11 + 8'(i));
        popCheck("t6_pop_last", 8'h99);
        checkOutput("t6_empty", bus.ready, 1'b0);

        // Stop-bit error, a good byte, then clr mid-frame
        applyStimulus(mkFrame(8'h33, 1'b1, 1'b0), 11, 1'b0);
        checkOutput("t7_stop_err", frameErr, 1'b1);
        applyStimulus(mkFrame(8'h3C, 1'b1, 1'b1), 11, 1'b0);
        checkOutput("t7_ready_pre", bus.ready, 1'b1);
        applyStimulus(mkFrame(8'h77, 1'b0, 1'b1), 4, 1'b0);
        pulseClr();
        checkOutput("t7_clr_ready", bus.ready, 1'b0);
        checkOutput("t7_clr_data", bus.data, 8'h00);
        checkOutput("t7_clr_overflow", overflow, 1'b0);
        checkOutput("t7_clr_frame_err", frameErr, 1'b0);
        applyStimulus(mkFrame(8'hA5, 1'b1, 1'b1), 11, 1'b0);
        checkOutput("t7_after_ready", bus.ready, 1'b1);
        popCheck("t7_after_data", 8'hA5);

        running = 0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
